// File: rtl/hilo_mac_pkg.sv
// Shared definitions for the HI/LO multiply-accumulate unit: opcode encodings,
// opcode predicates, stage-1 operation kinds and default reset constants.
package hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  localparam int unsigned HI_RST_DEF = 0;
  localparam int unsigned LO_RST_DEF = 0;

  typedef enum logic [1:0] {
    KIND_MULT = 2'd0,
    KIND_MADD = 2'd1,
    KIND_MSUB = 2'd2
  } mul_kind_e;

  function automatic logic is_mul(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return op inside {OP_MADD, OP_MADDU};
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/hilo_mul_stage.sv
// Stage 1 of the HI/LO unit: registered DATA_W x DATA_W signed/unsigned
// multiplier with its valid bit and operation kind; flush and reset drop it.
module hilo_mul_stage
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       flush,
  input  logic [3:0]                 op,
  input  logic [DATA_W-1:0]          a,
  input  logic [DATA_W-1:0]          b,
  output logic                       vld_p1,
  output mul_kind_e                  kind_p1,
  output logic signed [2*DATA_W-1:0] prod_p1
);

  logic                       vld_p1_d, vld_p1_q;
  mul_kind_e                  kind_p1_d, kind_p1_q;
  logic signed [2*DATA_W-1:0] prod_p1_d, prod_p1_q;
  logic signed [2*DATA_W-1:0] a_ext, b_ext;
  logic                       sgn;

  // Extending both operands to 2*DATA_W lets one truncated multiply serve
  // both signed and unsigned variants.
  always_comb begin
    sgn       = is_signed(op);
    a_ext     = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    b_ext     = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    prod_p1_d = a_ext * b_ext;
    vld_p1_d  = start && !flush;
    kind_p1_d = KIND_MULT;
    if (is_acc(op)) begin
      kind_p1_d = KIND_MADD;
    end else if (is_sub(op)) begin
      kind_p1_d = KIND_MSUB;
    end
  end

  // ---- stage 1 register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      prod_p1_q <= prod_p1_d;
      kind_p1_q <= kind_p1_d;
    end
  end

  assign vld_p1  = vld_p1_q;
  assign kind_p1 = kind_p1_q;
  assign prod_p1 = prod_p1_q;

endmodule

// File: rtl/hilo_mac.sv
// HI/LO register pair with MTHI/MTLO and a 2-stage MULT/MADD/MSUB pipeline.
// Optional macro HILO_MAC_FWD_EN forwards the stage-2 result to hi_o/lo_o.
module hilo_mac
  import hilo_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] HI_RST = DATA_W'(HI_RST_DEF),
  parameter logic [DATA_W-1:0] LO_RST = DATA_W'(LO_RST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  input  logic              rd_req,
  output logic              stall_req,
  output logic              busy,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int PW = 2 * DATA_W;

  logic                 accept, start, fire;
  logic                 vld_p1;
  mul_kind_e            kind_p1;
  logic signed [PW-1:0] prod_p1;
  logic signed [PW-1:0] res_p2;
  logic signed [PW-1:0] hilo_d, hilo_q;
  logic signed [PW-1:0] hilo_view;

  // Modulo 2^PW accumulate; no saturation, overflow simply wraps.
  function automatic logic signed [PW-1:0] acc_result(
    input mul_kind_e            kind,
    input logic signed [PW-1:0] acc,
    input logic signed [PW-1:0] prod
  );
    case (kind)
      KIND_MADD: return acc + prod;
      KIND_MSUB: return acc - prod;
      default:   return prod;
    endcase
  endfunction

  assign busy     = vld_p1;
  assign op_ready = !busy;
  assign accept   = op_valid && op_ready && !flush;
  assign start    = accept && is_mul(op);
  assign fire     = vld_p1 && !flush;

  hilo_mul_stage #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .a       (rs_data),
    .b       (rt_data),
    .vld_p1  (vld_p1),
    .kind_p1 (kind_p1),
    .prod_p1 (prod_p1)
  );

  always_comb begin
    res_p2 = acc_result(kind_p1, hilo_q, prod_p1);
    hilo_d = hilo_q;
    if (fire) begin
      hilo_d = res_p2;
    end else if (accept && op == OP_MTHI) begin
      hilo_d[PW-1:DATA_W] = rs_data;
    end else if (accept && op == OP_MTLO) begin
      hilo_d[DATA_W-1:0] = rs_data;
    end
  end

  // ---- stage 2 register boundary (architectural HI/LO) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_q <= {HI_RST, LO_RST};
    end else begin
      hilo_q <= hilo_d;
    end
  end

`ifdef HILO_MAC_FWD_EN
  logic unused_rd_req;
  assign unused_rd_req = rd_req;
  assign hilo_view     = fire ? res_p2 : hilo_q;
  assign stall_req     = 1'b0;
`else
  assign hilo_view     = hilo_q;
  assign stall_req     = rd_req && busy;
`endif

  assign hi_o = hilo_view[PW-1:DATA_W];
  assign lo_o = hilo_view[DATA_W-1:0];

endmodule

// File: tb/tb_hilo_mac.sv
// Scoreboard bench for hilo_mac: a transaction-level HI/LO model queues the
// expected per-cycle outputs, and a negedge monitor pops and compares them.
module tb_hilo_mac;
  import hilo_pkg::*;

`ifdef HILO_MAC_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, flush, rd_req, stall_req, busy;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data, hi_o, lo_o;

  hilo_mac #(.DATA_W(32), .HI_RST(32'h0), .LO_RST(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .rd_req    (rd_req),
    .stall_req (stall_req),
    .busy      (busy),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        ready;
    logic        stall;
  } item_t;

  item_t sbq[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: architectural HI/LO plus one pending multiply.
  logic [31:0] m_hi, m_lo;
  bit          m_busy;
  int          m_kind;   // 0 = overwrite, 1 = add, 2 = subtract
  logic [63:0] m_prod;

  function automatic logic [63:0] pending_result();
    logic [63:0] acc;
    acc = {m_hi, m_lo};
    if (m_kind == 1) return acc + m_prod;
    if (m_kind == 2) return acc - m_prod;
    return m_prod;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v, input int c);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, exp_v);
    end
  endtask

  // Monitor: pops every expectation due this cycle.
  always @(negedge clk) begin
    item_t it;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      it = sbq.pop_front();
      if (it.due < cyc) begin
        checks++;
        failures++;
        $display("FAIL stale_item due=%0d actual_cyc=%0d", it.due, cyc);
      end else begin
        cmp("hi_o", hi_o, it.hi, cyc);
        cmp("lo_o", lo_o, it.lo, cyc);
        cmp("busy", {31'b0, busy}, {31'b0, it.busy}, cyc);
        cmp("op_ready", {31'b0, op_ready}, {31'b0, it.ready}, cyc);
        cmp("stall_req", {31'b0, stall_req}, {31'b0, it.stall}, cyc);
      end
    end
  end

  // One cycle: drive inputs, queue this cycle's expectation, clock, update model.
  task automatic step(input bit v, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit fl, input bit rd);
    item_t it;
    logic [63:0] view;
    op_valid = v; op = o; rs_data = a; rt_data = b; flush = fl; rd_req = rd;
    view = (FWD && m_busy && !fl) ? pending_result() : {m_hi, m_lo};
    it.due   = cyc;
    it.hi    = view[63:32];
    it.lo    = view[31:0];
    it.busy  = m_busy;
    it.ready = !m_busy;
    it.stall = !FWD && rd && m_busy;
    sbq.push_back(it);
    @(posedge clk);
    #1;
    if (rst) begin
      if (m_busy) begin
        if (!fl) {m_hi, m_lo} = pending_result();
        m_busy = 1'b0;
      end else if (v && !fl) begin
        if (o == OP_MTHI) m_hi = a;
        else if (o == OP_MTLO) m_lo = a;
        else if (is_mul(o)) begin
          if (is_signed(o)) m_prod = 64'(longint'(int'(a)) * longint'(int'(b)));
          else              m_prod = {32'd0, a} * {32'd0, b};
          m_kind = is_acc(o) ? 1 : (is_sub(o) ? 2 : 0);
          m_busy = 1'b1;
        end
      end
    end
    op_valid = 1'b0; flush = 1'b0; rd_req = 1'b0;
  endtask

  task automatic idle(input bit rd = 1'b0, input bit fl = 1'b0);
    step(1'b0, OP_NOP, 32'h0, 32'h0, fl, rd);
  endtask

  // Called at the start of a busy cycle: reset drops between edges.
  task automatic reset_mid();
    item_t it;
    op_valid = 1'b0; flush = 1'b0; rd_req = 1'b1;
    #1 rst = 1'b0;
    it.due = cyc; it.hi = 32'h0; it.lo = 32'h0;
    it.busy = 1'b0; it.ready = 1'b1; it.stall = 1'b0;
    sbq.push_back(it);
    m_hi = 32'h0; m_lo = 32'h0; m_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; rd_req = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edge_vals [5];
    edge_vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 2) == 0) return edge_vals[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b0; op_valid = 1'b0; op = OP_NOP; rs_data = '0; rt_data = '0;
    flush = 1'b0; rd_req = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0; m_busy = 1'b0; m_kind = 0; m_prod = '0;
    @(posedge clk);
    #1;
    idle();            // checked while still in reset
    rst = 1'b1;

    // MTHI/MTLO
    step(1, OP_MTHI, 32'h12345678, 32'h0, 0, 0);
    step(1, OP_MTLO, 32'h9ABCDEF0, 32'h0, 0, 0);
    idle();

    // Signed MULT -1 * 2
    step(1, OP_MULT, 32'hFFFFFFFF, 32'h2, 0, 0);
    idle(); idle(); idle();

    // MADDU wraps to zero
    step(1, OP_MTHI, 32'hFFFFFFFF, 32'h0, 0, 0);
    step(1, OP_MTLO, 32'hFFFFFFFF, 32'h0, 0, 0);
    step(1, OP_MADDU, 32'h1, 32'h1, 0, 0);
    idle(); idle();

    // MSUB 10 - 12 = -2
    step(1, OP_MTHI, 32'h0, 32'h0, 0, 0);
    step(1, OP_MTLO, 32'd10, 32'h0, 0, 0);
    step(1, OP_MSUB, 32'd3, 32'd4, 0, 0);
    idle(); idle();

    // Stall during busy cycle only
    step(1, OP_MULT, 32'd5, 32'd7, 0, 0);
    idle(1'b1); idle(1'b1);

    // Flush the in-flight multiply
    step(1, OP_MADD, 32'd9, 32'd9, 0, 0);
    idle(1'b1, 1'b1); idle(); idle();

    // Flush blocks an offered op, and an op offered while busy is refused
    step(1, OP_MTHI, 32'hDEADBEEF, 32'h0, 1, 0);
    step(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    step(1, OP_MTLO, 32'h55555555, 32'h0, 0, 0);
    idle(); idle();

    // Undefined opcode behaves as NOP
    step(1, 4'hC, 32'hAAAAAAAA, 32'h3, 0, 0);
    idle();

    // Asynchronous reset in the middle of a multiply
    step(1, OP_MTHI, 32'h11111111, 32'h0, 0, 0);
    step(1, OP_MSUBU, 32'h1234, 32'h5678, 0, 0);
    reset_mid();
    idle(); idle();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    end
    idle(); idle();

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hilo_mac.md
Name: hilo_mac

Overview:
- Parametrised successor to the HI/LO pair register.
- Holds HI/LO and executes MTHI/MTLO, MULT/MULTU and multiply-accumulate MADD/MADDU/MSUB/MSUBU in a 2-stage pipeline.
- Sits beside the EX stage. Provides a valid/ready op handshake, a stall request for MFHI/MFLO reads that hit an in-flight multiply, and a flush for squashed instructions.

Parameters:
- DATA_W, 32, width of HI, LO and each operand. Product width is 2*DATA_W.
- HI_RST, 0, reset value of HI.
- LO_RST, 0, reset value of LO.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation offered this cycle.
- op_ready  out  1  operation accepted when op_valid && op_ready at the edge.
- op  in  4  opcode, encodings in the package.
- rs_data  in  DATA_W  operand A; also the MTHI/MTLO source.
- rt_data  in  DATA_W  operand B.
- flush  in  1  squash the op in stage 1.
- rd_req  in  1  EX stage is reading HI or LO (MFHI/MFLO).
- stall_req  out  1  rd_req while a result is pending.
- busy  out  1  stage 1 occupied.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.

Behaviour:
- Reset (rst=0, asynchronous):
  - hi_o=HI_RST, lo_o=LO_RST.
  - Stage-1 valid cleared, busy=0, op_ready=1, stall_req=0.
  - Takes effect mid-operation; the pending product is discarded.
- op_ready = !busy. Only one multiply is in flight, so no accumulate hazard exists.
- Opcodes: OP_NOP, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU. Undefined codes are treated as OP_NOP.
- MTHI/MTLO when accepted:
  - HI (or LO) <= rs_data at that edge; the other register is unchanged.
  - Latency 1; busy stays 0.
- Multiply class when accepted:
  - Edge N (stage 1): registers the 2*DATA_W product. Signed for MULT/MADD/MSUB, unsigned for the U variants. Also registers the op kind. busy=1 during cycle N+1.
  - Edge N+1 (stage 2):
    - MULT*: {HI,LO} <= product.
    - MADD*: {HI,LO} <= {HI,LO} + product.
    - MSUB*: {HI,LO} <= {HI,LO} - product.
  - Arithmetic is modulo 2^(2*DATA_W), with no overflow flag.
  - busy returns to 0 after edge N+1.
  - Total latency: 2 edges from acceptance to visible hi_o/lo_o.
- Throughput: one multiply every 2 cycles. MTHI/MTLO is also blocked while busy.
- flush:
  - flush=1 while busy: stage 1 is cleared at the next edge, HI/LO are not written, busy=0 next cycle.
  - flush=1 with op_valid in the same cycle: the offered op is not accepted, even if op_ready=1.
  - flush has priority over acceptance.
- stall_req = rd_req && busy, purely combinational.
- With rd_req=1 and busy=0: hi_o/lo_o already reflect every completed op.

Optional Feature:
- Macro: HILO_MAC_FWD_EN.
- Defined:
  - stall_req is removed (tied 0).
  - hi_o/lo_o present the stage-2 result combinationally during the busy cycle, i.e. the value HI/LO will hold after the edge. This makes MFHI immediately after a multiply stall-free.
  - Timing cost: the 2*DATA_W adder sits in the output path.
- Undefined:
  - hi_o/lo_o are pure register outputs.
  - stall_req is used as described in Behaviour.

Decomposition:
- Package hilo_pkg holds:
  - The 4-bit op encodings (OP_NOP..OP_MSUBU).
  - Helper predicates: is_mul, is_signed, is_acc, is_sub.
  - The default reset constants.
- Sub-module hilo_mul_stage holds the registered signed/unsigned DATA_W x DATA_W multiplier plus stage-1 valid/kind. Flush and reset clear it.
- Top level holds the handshake, the accumulate adder/subtractor and the HI/LO registers.

Test Plan:
- Reset/MT:
  - Stimulus: rst low, then MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0.
  - Required: after reset hi_o=lo_o=0; after the two ops hi_o=0x12345678, lo_o=0x9ABCDEF0. busy never asserts.
- Signed MULT:
  - Stimulus: rs=0xFFFFFFFF (-1), rt=0x00000002.
  - Required: two edges later hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. op_ready=0 for exactly one cycle.
- MADDU wrap:
  - Stimulus: HI=0xFFFFFFFF, LO=0xFFFFFFFF; MADDU rs=1, rt=1.
  - Required: hi_o=0, lo_o=0 (modulo wrap).
- MSUB:
  - Stimulus: HI=0, LO=10; MSUB rs=3, rt=4.
  - Required: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE (-2).
- Stall and flush:
  - Stimulus: MULT, then rd_req=1 in the busy cycle.
  - Required: stall_req=1 for that cycle only.
  - Stimulus: repeat with flush=1 in the busy cycle.
  - Required: HI/LO unchanged and busy=0 next cycle.
- Async reset mid-op:
  - Stimulus: assert rst between edges during busy.
  - Required: busy, hi_o and lo_o go to their reset values immediately, without waiting for a clock edge. With HILO_MAC_FWD_EN defined, stall_req is constant 0 and hi_o is correct in the busy cycle.
